pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage segmented core. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable. It resolves three conditions:
- load-use data hazards;
- EX-stage control redirects (branch/jump);
- multi-cycle data-memory accesses, with a timeout watchdog.

It also exports a stall-cycle performance counter.

Parameters:
WAIT_MAX, 15, max additional cycles a data-memory access may stall before timeout (≥1)
CNT_W, 16, width of stall-cycle counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
id_rs1_i  in  5  rs1 of instruction in ID
id_rs2_i  in  5  rs2 of instruction in ID
id_uses_rs1_i  in  1  ID instruction reads rs1
id_uses_rs2_i  in  1  ID instruction reads rs2
ex_rd_i  in  5  rd of instruction in EX (ID/EX latch output)
ex_memread_i  in  1  EX instruction is a load
ex_branch_taken_i  in  1  taken branch resolved in EX
ex_jump_i  in  1  jump resolved in EX
mem_req_i  in  1  EX/MEM instruction accesses data memory this cycle
mem_ack_i  in  1  data memory completes access
pc_en_o  out  1  PC update enable
if_id_en_o  out  1  IF/ID latch enable
if_id_flush_o  out  1  IF/ID load bubble
id_ex_en_o  out  1  ID/EX latch enable
id_ex_flush_o  out  1  ID/EX load bubble
ex_mem_en_o  out  1  EX/MEM latch enable
mem_wb_flush_o  out  1  MEM/WB load bubble (regwrite=0)
mem_timeout_o  out  1  sticky memory timeout flag
stall_cnt_o  out  CNT_W  cycles with pc_en_o=0, saturating
state_o  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERROR

Behaviour:
Definitions (combinational):
- memstall = mem_req_i & ~mem_ack_i
- redirect = ex_branch_taken_i | ex_jump_i
- loaduse = ex_memread_i & (ex_rd_i≠0) & ((id_uses_rs1_i & id_rs1_i==ex_rd_i) | (id_uses_rs2_i & id_rs2_i==ex_rd_i))

Output decode (Mealy, same-cycle). Default: all enables 1, all flushes 0.

RUN state, priority memstall > redirect > loaduse:
- memstall: pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_flush = 1; next state MEM_WAIT; wait_cnt <= 1.
- redirect: if_id_flush = 1, id_ex_flush = 1, enables 1; stay RUN. A loaduse in the same cycle is ignored, because the ID instruction is squashed.
- loaduse: pc_en = 0, if_id_en = 0, id_ex_flush = 1; stay RUN. The load advances, so the hazard clears next cycle and exactly one bubble is inserted.

MEM_WAIT state:
- mem_ack_i = 0: same freeze as the memstall decode. If wait_cnt == WAIT_MAX, next state ERROR; else wait_cnt++.
- mem_ack_i = 1: release cycle. mem_req_i is ignored; redirect and loaduse are evaluated as in RUN (their inputs were held while frozen); next state RUN.
- A redirect pending during the wait is therefore applied on the release cycle, never lost.

ERROR state:
- All enables 0, all flushes 0, mem_timeout_o = 1.
- Held until reset; no exit otherwise.
- Result: an access is accepted if mem_ack_i arrives within WAIT_MAX+1 stalled cycles, counting the request cycle.

stall_cnt_o:
- Increments on every clk_i edge where pc_en_o = 0, including ERROR cycles.
- Saturates at all-ones; no wrap.

Reset (asynchronous, rst_ni low):
- state = RUN, wait_cnt = 0, mem_timeout_o = 0, stall_cnt_o = 0, state_o = 0.
- Combinational outputs follow the RUN decode of the current inputs.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN immediately.

Registers update only on the rising edge of clk_i.

Test Plan:
1. Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1, no memstall -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt 0→1. Next cycle with ex_memread=0: all enables 1.
2. Load with rd=0: ex_rd=0, id_rs1=0, id_uses_rs1=1 -> no stall; outputs at default.
3. Redirect plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1; stall_cnt unchanged.
4. Memory wait: mem_req=1, ack on the 4th cycle -> 3 frozen cycles with mem_wb_flush=1 and state_o 0→1→1→1; release cycle with enables 1 and state_o back to 0; stall_cnt=3. Repeat with ex_jump_i=1 held -> flushes asserted only on the release cycle.
5. Timeout: WAIT_MAX=15, mem_req=1, never ack -> 16 frozen cycles, then state_o=2 and mem_timeout_o=1 from cycle 17 onward. Asserting rst_ni=0 -> state_o=0, mem_timeout_o=0, stall_cnt_o=0 immediately (asynchronous).
6. Saturation: CNT_W=4, hold a memstall 20 cycles with WAIT_MAX=31 -> stall_cnt_o stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage core. Drives the PC enable and
// the enable/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
// It resolves load-use hazards, EX-stage redirects (taken branch or jump) and
// multi-cycle data-memory accesses. A watchdog parks the core in ERROR when a
// memory access stalls for too long.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   id_rs1_i/id_rs2_i    source registers of the ID instruction
//   id_uses_rs1/2_i      ID instruction actually reads rs1/rs2
//   ex_rd_i              destination of the EX instruction
//   ex_memread_i         EX instruction is a load
//   ex_branch_taken_i    taken branch resolved in EX
//   ex_jump_i            jump resolved in EX
//   mem_req_i/mem_ack_i  data-memory request / completion
//   pc_en_o .. mem_wb_flush_o  pipeline latch controls (Mealy, same cycle)
//   mem_timeout_o        sticky timeout flag (set while in ERROR)
//   stall_cnt_o          saturating count of cycles with pc_en_o = 0
//   state_o              0 RUN, 1 MEM_WAIT, 2 ERROR
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             ex_branch_taken_i,
    input  logic             ex_jump_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_en_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_en_o,
    output logic             mem_wb_flush_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [1:0]       state_o
);

    localparam int unsigned WCW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic memstall, redirect, loaduse;
    logic resolve;  // redirect/load-use decode applies this cycle

    assign memstall = mem_req_i & ~mem_ack_i;
    assign redirect = ex_branch_taken_i | ex_jump_i;
    assign loaduse  = ex_memread_i & (ex_rd_i != 5'd0) &
                      ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
                       (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_en_o     = 1'b1;
        id_ex_flush_o  = 1'b0;
        ex_mem_en_o    = 1'b1;
        mem_wb_flush_o = 1'b0;
        resolve        = 1'b0;
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;

        unique case (state_q)
            ST_RUN: begin
                if (memstall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WCW'(1);
                end else begin
                    resolve = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ack_i) begin
                    if (wait_cnt_q == WCW'(WAIT_MAX)) begin
                        state_d = ST_ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end else begin
                    // Release cycle: the request is done, so apply whatever
                    // redirect/load-use was held upstream during the freeze.
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                    resolve    = 1'b1;
                end
            end
            ST_ERROR: begin
                pc_en_o     = 1'b0;
                if_id_en_o  = 1'b0;
                id_ex_en_o  = 1'b0;
                ex_mem_en_o = 1'b0;
            end
            default: state_d = ST_RUN;
        endcase

        // Freeze everything upstream of MEM and bubble into WB while the
        // memory access is outstanding.
        if ((state_q == ST_RUN && memstall) ||
            (state_q == ST_MEM_WAIT && !mem_ack_i)) begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            ex_mem_en_o    = 1'b0;
            mem_wb_flush_o = 1'b1;
        end

        if (resolve) begin
            if (redirect) begin
                // The ID instruction is squashed, so a load-use on it is moot.
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (loaduse) begin
                pc_en_o       = 1'b0;
                if_id_en_o    = 1'b0;
                id_ex_flush_o = 1'b1;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_en_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample their next value from the same pre-edge snapshot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_timeout_o = (state_q == ST_ERROR);
    assign stall_cnt_o   = stall_cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
    logic        id_uses_rs1_i, id_uses_rs2_i, ex_memread_i;
    logic        ex_branch_taken_i, ex_jump_i, mem_req_i, mem_ack_i;

    logic        pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o;
    logic        id_ex_flush_o, ex_mem_en_o, mem_wb_flush_o, mem_timeout_o;
    logic [15:0] stall_cnt_o;
    logic [1:0]  state_o;

    logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en;
    logic        s_id_ex_flush, s_ex_mem_en, s_mem_wb_flush, s_timeout;
    logic [3:0]  s_stall_cnt;
    logic [1:0]  s_state;

    always #5 clk_i = ~clk_i;

    pipeline_hazard_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .ex_rd_i(ex_rd_i), .ex_memread_i(ex_memread_i),
        .ex_branch_taken_i(ex_branch_taken_i), .ex_jump_i(ex_jump_i),
        .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .pc_en_o(pc_en_o), .if_id_en_o(if_id_en_o), .if_id_flush_o(if_id_flush_o),
        .id_ex_en_o(id_ex_en_o), .id_ex_flush_o(id_ex_flush_o),
        .ex_mem_en_o(ex_mem_en_o), .mem_wb_flush_o(mem_wb_flush_o),
        .mem_timeout_o(mem_timeout_o), .stall_cnt_o(stall_cnt_o), .state_o(state_o)
    );

    // Small-counter instance used for the saturation and long-wait checks.
    pipeline_hazard_ctrl #(.WAIT_MAX(31), .CNT_W(4)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .ex_rd_i(ex_rd_i), .ex_memread_i(ex_memread_i),
        .ex_branch_taken_i(ex_branch_taken_i), .ex_jump_i(ex_jump_i),
        .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .pc_en_o(s_pc_en), .if_id_en_o(s_if_id_en), .if_id_flush_o(s_if_id_flush),
        .id_ex_en_o(s_id_ex_en), .id_ex_flush_o(s_id_ex_flush),
        .ex_mem_en_o(s_ex_mem_en), .mem_wb_flush_o(s_mem_wb_flush),
        .mem_timeout_o(s_timeout), .stall_cnt_o(s_stall_cnt), .state_o(s_state)
    );

    // Control vector {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    //                 ex_mem_en, mem_wb_flush, mem_timeout}
    localparam logic [7:0] C_DEF = 8'b1101_0100;
    localparam logic [7:0] C_LU  = 8'b0001_1100;
    localparam logic [7:0] C_RD  = 8'b1111_1100;
    localparam logic [7:0] C_FRZ = 8'b0000_0010;
    localparam logic [7:0] C_ERR = 8'b0000_0001;

    typedef struct {
        string       tag;
        logic [7:0]  ctl;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic mr, input logic br, input logic jp,
                          input logic req, input logic ack);
        id_rs1_i = rs1; id_rs2_i = rs2; id_uses_rs1_i = u1; id_uses_rs2_i = u2;
        ex_rd_i = rd; ex_memread_i = mr; ex_branch_taken_i = br; ex_jump_i = jp;
        mem_req_i = req; mem_ack_i = ack;
    endtask

    task automatic push(input string tag, input logic [7:0] ctl,
                        input logic [1:0] st, input int cnt);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.st = st; e.cnt = 16'(cnt);
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it against the live outputs.
    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected entry");
        end else begin
            e = sb.pop_front();
            check({e.tag, " ctl"}, 32'({pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o,
                                       id_ex_flush_o, ex_mem_en_o, mem_wb_flush_o,
                                       mem_timeout_o}), 32'(e.ctl));
            check({e.tag, " state"}, 32'(state_o), 32'(e.st));
            check({e.tag, " cnt"}, 32'(stall_cnt_o), 32'(e.cnt));
        end
    endtask

    // Inputs are already applied; sample mid-cycle, then advance one edge.
    task automatic cycle();
        @(negedge clk_i);
        compare_head();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        push("reset", C_DEF, 0, 0);
        compare_head();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Load-use on rs2, then the load has moved on.
        set_in(1, 5, 0, 1, 5, 1, 0, 0, 0, 0); push("lu_rs2", C_LU, 0, 0); cycle();
        set_in(1, 5, 0, 1, 5, 0, 0, 0, 0, 0); push("lu_clear", C_DEF, 0, 1); cycle();
        // Load-use on rs1; then same register but rs1 not read.
        set_in(7, 2, 1, 0, 7, 1, 0, 0, 0, 0); push("lu_rs1", C_LU, 0, 1); cycle();
        set_in(7, 2, 0, 1, 7, 1, 0, 0, 0, 0); push("lu_unused", C_DEF, 0, 2); cycle();
        // Load to x0 never stalls.
        set_in(0, 0, 1, 1, 0, 1, 0, 0, 0, 0); push("lu_x0", C_DEF, 0, 2); cycle();
        // Redirect wins over a simultaneous load-use.
        set_in(5, 0, 1, 0, 5, 1, 1, 0, 0, 0); push("br_lu", C_RD, 0, 2); cycle();
        set_in(5, 0, 1, 0, 5, 1, 0, 1, 0, 0); push("jmp_lu", C_RD, 0, 2); cycle();
        // Request acknowledged in its own cycle is not a stall.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); push("req_ack", C_DEF, 0, 2); cycle();

        // Memory wait, ack on 4th cycle.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        push("mw1", C_FRZ, 0, 2); cycle();
        push("mw2", C_FRZ, 1, 3); cycle();
        push("mw3", C_FRZ, 1, 4); cycle();
        mem_ack_i = 1'b1; push("mw_rel", C_DEF, 1, 5); cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); push("mw_after", C_DEF, 0, 5); cycle();

        // Same wait with a jump held: flushes only on the release cycle.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        push("mwj1", C_FRZ, 0, 5); cycle();
        push("mwj2", C_FRZ, 1, 6); cycle();
        push("mwj3", C_FRZ, 1, 7); cycle();
        mem_ack_i = 1'b1; push("mwj_rel", C_RD, 1, 8); cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); push("mwj_after", C_DEF, 0, 8); cycle();

        // Load-use held across a wait is applied on release.
        set_in(0, 5, 0, 1, 5, 1, 0, 0, 1, 0); push("mwl1", C_FRZ, 0, 8); cycle();
        mem_ack_i = 1'b1; push("mwl_rel", C_LU, 1, 9); cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); push("mwl_after", C_DEF, 0, 10); cycle();

        // Timeout: 16 frozen cycles, then ERROR from cycle 17 on.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            push($sformatf("to_frz%0d", i), C_FRZ, (i == 0) ? 2'd0 : 2'd1, 10 + i);
            cycle();
        end
        for (int i = 16; i < 19; i++) begin
            push($sformatf("to_err%0d", i), C_ERR, 2, 10 + i);
            cycle();
        end
        // ERROR is not left on a late ack or redirect.
        mem_ack_i = 1'b1; ex_jump_i = 1'b1;
        push("err_ack", C_ERR, 2, 29); cycle();

        // Asynchronous reset mid-cycle.
        rst_ni = 1'b0;
        #1;
        push("async_rst", C_RD, 0, 0);
        compare_head();
        check("sat rst cnt", 32'(s_stall_cnt), 32'd0);
        #2;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Saturation on the 4-bit counter during a 20-cycle stall.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            check($sformatf("sat_cnt%0d", i), 32'(s_stall_cnt), (i < 15) ? i : 15);
            @(posedge clk_i);
            #1;
        end
        @(negedge clk_i);
        check("sat_final", 32'(s_stall_cnt), 32'd15);
        check("sat_state", 32'(s_state), 32'd1);
        check("sat_no_to", 32'(s_timeout), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
